// File: rtl/esc_serial_tx_scheduler.sv
// esc_serial_tx_scheduler
//
// Buffers bytes from the USB RX byte stream in a small FIFO and schedules
// them onto the half-duplex ESC serial transmitter with a valid/ready
// handshake. The block owns the ESC line for the whole burst (plus an
// optional post-burst guard time), so pad OE gating and RX blanking stay
// steady between back-to-back bytes.
//
// Optional feature macro: ESC_TX_GUARD_EN
//   defined   : GUARD state and counter hold the line for GUARD_CYCLES
//               cycles after the last byte finishes.
//   undefined : the line is released the cycle after the TX goes idle.
//
// Parameters:
//   CLK_FREQ_HZ  system clock frequency
//   BAUD_RATE    ESC serial baud rate
//   FIFO_DEPTH   byte FIFO entries (power of two, >= 2)
//   GUARD_BITS   bit times the line stays owned after the last stop bit
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   enable     passthrough enable; low flushes the FIFO and forces IDLE
//   in_data    byte from the USB RX
//   in_valid   one-cycle write strobe (no backpressure)
//   out_data   FIFO head, offered to the ESC TX
//   out_valid  byte offered to the ESC TX
//   out_ready  ESC TX ready to accept
//   tx_active  ESC TX is shifting bits
//   line_own   block owns the line (pad OE gating)
//   rx_blank   suppress ESC RX forwarding (same as line_own)
//   overflow   sticky: a byte was dropped because the FIFO was full
//   level      current FIFO occupancy
module esc_serial_tx_scheduler #(
    parameter int CLK_FREQ_HZ = 72_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 16,
    parameter int GUARD_BITS  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          tx_active,
    output logic                          line_own,
    output logic                          rx_blank,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

`ifdef ESC_TX_GUARD_EN
    localparam int GUARD_CYCLES = (CLK_FREQ_HZ / BAUD_RATE) * GUARD_BITS;
    localparam int GW = (GUARD_CYCLES > 2) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        GUARD
    } state_t;

    logic [GW-1:0] guard_cnt;
`else
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE
    } state_t;
`endif

    state_t state;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full      = (count == FULL_LEVEL);
    assign empty     = (count == '0);
    assign out_valid = (state == SEND);
    assign line_own  = (state != IDLE);
    assign rx_blank  = line_own;
    assign out_data  = mem[rd_ptr];
    assign level     = count;

    assign pop  = out_valid & out_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push = in_valid & enable & (!full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_valid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state <= IDLE;
`ifdef ESC_TX_GUARD_EN
            guard_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (out_ready && !tx_active) begin
                        if (!empty) begin
                            state <= SEND;
                        end else begin
`ifdef ESC_TX_GUARD_EN
                            state     <= GUARD;
                            guard_cnt <= GUARD_LOAD;
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
`ifdef ESC_TX_GUARD_EN
                GUARD: begin
                    // A new byte during the guard keeps ownership and resumes sending.
                    if (!empty) begin
                        state <= SEND;
                    end else if (guard_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/esc_serial_tx_scheduler.md
# esc_serial_tx_scheduler

Buffers bytes arriving from the USB UART receiver and schedules them onto the half-duplex ESC serial transmitter with a proper valid/ready handshake. Owns the ESC line across a byte burst, including a post-burst guard time, so receive blanking and pad output-enable never glitch between bytes. Sits between the USB RX byte stream and the ESC-side `uart_tx_wrapper` in the passthrough path. Absorbs bursts that a pulse-only forward from the USB side would otherwise drop.

## Interface
- `CLK_FREQ_HZ`, default 72_000_000: system clock frequency.
- `BAUD_RATE`, default 115200: ESC serial baud rate.
- `FIFO_DEPTH`, default 16: byte FIFO entries. Must be a power of two, ≥2.
- `GUARD_BITS`, default 2: bit times the line stays owned after the last stop bit.
- Derived: `GUARD_CYCLES = (CLK_FREQ_HZ/BAUD_RATE)*GUARD_BITS`, integer division. With defaults this is 625*2 = 1250.

Ports:
- `clk`  in  1: system clock. This is the only clock.
- `rst`  in  1: reset, synchronous and active-high.
- `enable`  in  1: passthrough enabled. Low flushes the block and forces IDLE.
- `in_data`  in  8: byte from the USB RX.
- `in_valid`  in  1: one-cycle write strobe. There is no backpressure on this input.
- `out_data`  out  8: byte to the ESC TX. Equals the FIFO head.
- `out_valid`  out  1: byte offered to the ESC TX.
- `out_ready`  in  1: ESC TX ready to accept.
- `tx_active`  in  1: ESC TX is shifting bits.
- `line_own`  out  1: block owns the line. Drives pad OE gating.
- `rx_blank`  out  1: suppress ESC RX forwarding. Equals `line_own`.
- `overflow`  out  1: sticky flag, set when a byte is dropped because the FIFO is full.
- `level`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- FIFO:
  - A write occurs on `in_valid & enable & (!full | pop)`.
  - A pop occurs on the `out_valid & out_ready` handshake.
  - Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
  - `level` is ±1 per event, and unchanged when a write and a pop happen in the same cycle.
- Full and `in_valid` with no pop in the same cycle: the byte is dropped and `overflow` is set.
- Full and `in_valid` with a pop in the same cycle: the byte is accepted.
- `overflow` clears only on `rst` or while `enable` = 0.
- FSM states:
  - IDLE: if `enable` and FIFO is not empty, go to SEND.
  - SEND: `out_valid` = 1. On handshake, go to WAIT_DONE.
  - WAIT_DONE: stay a minimum of 1 cycle. Then, when `out_ready & !tx_active`:
    - FIFO not empty: go to SEND (back-to-back bytes).
    - FIFO empty: go to GUARD, loading the counter with `GUARD_CYCLES-1`.
  - GUARD: counter decrements each cycle.
    - FIFO becomes not empty: go to SEND immediately, keeping line ownership.
    - Counter reaches 0 with FIFO empty: go to IDLE.
- `line_own` = (state != IDLE). `out_valid` = (state == SEND). Both are decoded from the registered state.
- `enable` = 0 in any cycle:
  - Next state is IDLE, the FIFO is emptied, and `overflow` clears.
  - A byte already handed to the TX is not recalled.

## Timing
- Reset values:
  - State IDLE.
  - `out_valid` = 0, `line_own` = 0, `rx_blank` = 0.
  - `overflow` = 0, `level` = 0.
  - `out_data` = FIFO head, don't-care when empty.
- Latency: `in_valid` sampled at edge E0 into an empty FIFO in IDLE gives `out_valid` high after edge E1, i.e. a 2-cycle latency.
- `out_valid` stays high until the handshake. `out_data` is stable while `out_valid` = 1.
- `line_own` rises in the same cycle as the first `out_valid`.
- `line_own` falls exactly `GUARD_CYCLES` cycles after the WAIT_DONE exit cycle, provided no new byte arrives.
- Reset or `enable` drop mid-GUARD or mid-WAIT_DONE: `line_own` is 0 the next cycle.

## Configuration
- `ESC_TX_GUARD_EN` defined: GUARD state and counter are compiled in, as described above.
- `ESC_TX_GUARD_EN` undefined:
  - GUARD is removed. WAIT_DONE with an empty FIFO goes directly to IDLE.
  - `line_own` falls the cycle after `out_ready & !tx_active`.
  - `GUARD_BITS` is ignored.

## Test plan
- Single byte 0xA5 at defaults, TX model ready 1 cycle later, `tx_active` for 6250 cycles:
  - `out_valid` rises 2 cycles after `in_valid`, and `out_data` = 0xA5.
  - `line_own` stays high until 1250 cycles after `tx_active` falls.
- Burst of 4 bytes 0x01–0x04 on consecutive cycles: `level` peaks at 4. Bytes are emitted in order and `line_own` never drops between bytes.
- 17 writes while TX is held not-ready (FIFO_DEPTH = 16): `level` = 16 and `overflow` = 1. The 17th byte is lost and the first 16 drain intact.
- FIFO full plus a write and a handshake in the same cycle: the byte is accepted, `level` stays 16, and `overflow` stays 0.
- Byte arrives at guard count 500: FSM goes to SEND with no `line_own` gap, and the new byte is transmitted.
- `enable` dropped with `level` = 5 during WAIT_DONE:
  - Next cycle: `level` = 0, `line_own` = 0, `overflow` = 0.
  - No further `out_valid` appears.
  - Repeat with `ESC_TX_GUARD_EN` undefined and check immediate release.
